// File: rtl/uart_rx_byte_buffer_pkg.sv
// rtl/uart_rx_byte_buffer_pkg.sv - shared FSM encoding and UART constants for the RX byte buffer
package uart_rx_byte_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    POP       = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int UART_CLKS_PER_BIT = 217;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count and simultaneous read/write
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_byte_buffer.sv
// rtl/uart_rx_byte_buffer.sv - buffers UART RX bytes and replays them to the TX, paced by its busy flag
module uart_rx_byte_buffer
  import uart_rx_byte_buffer_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_RX_DV,
  input  logic [7:0]             i_RX_Byte,
  input  logic                   i_TX_Active,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  output logic [7:0]             o_Last_Byte,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Empty,
  output logic                   o_Full,
  output logic                   o_Overflow
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          pop;
  logic          wr_en;
  logic [7:0]    head;

  assign pop   = (state == POP);
  assign wr_en = i_RX_DV & (~o_Full | pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .wr_en   (wr_en),
    .wr_data (i_RX_Byte),
    .rd_en   (pop),
    .rd_data (head),
    .count   (o_Count),
    .full    (o_Full),
    .empty   (o_Empty)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst || state != WAIT_BUSY) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Last byte follows every strobe, even one dropped on overflow.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Last_Byte <= '0;
      o_Overflow  <= 1'b0;
    end else if (i_RX_DV) begin
      o_Last_Byte <= i_RX_Byte;
      if (o_Full && !pop) begin
        o_Overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    o_TX_DV    = 1'b0;
    o_TX_Byte  = '0;
    case (state)
      IDLE: begin
        if (!o_Empty && !i_TX_Active) begin
          state_next = POP;
        end
      end
      POP: begin
        o_TX_DV    = 1'b1;
        o_TX_Byte  = head;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_TX_Active) begin
          state_next = WAIT_DONE;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!i_TX_Active) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte_buffer.sv
// tb/tb_uart_rx_byte_buffer.sv - scoreboard bench for uart_rx_byte_buffer
module tb_uart_rx_byte_buffer;
  import uart_rx_byte_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_active = 1'b0;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [7:0] last_byte;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int         passes = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         dv_log[$];
  logic       prev_dv = 1'b0;
  int         max_count = 0;
  bit         tx_hold = 1'b0;
  bit         tx_auto = 1'b1;
  int         tx_len = 20;
  int         tx_cnt = 0;

  uart_rx_byte_buffer #(.DEPTH(16), .BUSY_TIMEOUT(4)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .i_TX_Active (tx_active),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .o_Last_Byte (last_byte),
    .o_Count     (count),
    .o_Empty     (empty),
    .o_Full      (full),
    .o_Overflow  (overflow)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transmitter model: busy for tx_len cycles after each strobe, or held busy.
  initial forever begin
    @(negedge clk);
    if (tx_auto && tx_dv) tx_cnt = tx_len;
    if (tx_hold) tx_active = 1'b1;
    else if (tx_cnt > 0) begin
      tx_active = 1'b1;
      tx_cnt--;
    end else tx_active = 1'b0;
  end

  // Monitor: every TX strobe pops the scoreboard.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) prev_dv = 1'b0;
    else begin
      if (int'(count) > max_count) max_count = int'(count);
      if (tx_dv) begin
        check("tx_dv_gap", int'(prev_dv), 0);
        check("tx_dv_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tx_byte", int'(tx_byte), int'(exp_q.pop_front()));
        dv_log.push_back(cyc);
      end
      prev_dv = tx_dv;
    end
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_dv"}, int'(tx_dv), 0);
    check({tag, "_tx_byte"}, int'(tx_byte), 0);
    check({tag, "_last"}, int'(last_byte), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_empty"}, int'(empty), 1);
    check({tag, "_full"}, int'(full), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_state"}, int'(dut.state), int'(IDLE));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit expect_out);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_byte = b;
    if (expect_out) exp_q.push_back(b);
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && !(empty && dut.state == IDLE && !tx_active)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, int'(n < budget), 1);
  endtask

  initial begin
    int s;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // Single byte: last-byte update and 2-cycle latency
    dv_log.delete();
    @(negedge clk);
    rx_dv = 1'b1;
    rx_byte = 8'hA5;
    exp_q.push_back(8'hA5);
    s = cyc;
    @(posedge clk);
    #1;
    check("t1_last_byte", int'(last_byte), 8'hA5);
    @(negedge clk);
    rx_dv = 1'b0;
    wait_idle("t1_idle_wait", 80);
    check("t1_state_idle", int'(dut.state), int'(IDLE));
    check("t1_empty", int'(empty), 1);
    check("t1_dv_count", dv_log.size(), 1);
    check("t1_latency", (dv_log.size() > 0) ? dv_log[0] - s : -1, 2);

    // Burst of 5 bytes every 3 cycles against 20-cycle frames
    max_count = 0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      @(negedge clk);
    end
    wait_idle("t2_idle_wait", 300);
    check("t2_peak_count", max_count, 4);
    check("t2_overflow", int'(overflow), 0);
    check("t2_queue_drained", exp_q.size(), 0);

    // Overflow: 17 writes while TX stays busy
    tx_hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      send(8'(i), i < 16);
      if (i == 15) begin
        check("t3_full_at_16", int'(full), 1);
        check("t3_no_ovf_at_16", int'(overflow), 0);
      end
    end
    @(posedge clk);
    #1;
    check("t3_full", int'(full), 1);
    check("t3_overflow", int'(overflow), 1);
    check("t3_last_byte", int'(last_byte), 8'h10);
    check("t3_count", int'(count), 16);
    tx_len = 6;
    tx_hold = 1'b0;
    wait_idle("t3_drain_wait", 600);
    check("t3_queue_drained", exp_q.size(), 0);
    check("t3_ovf_sticky", int'(overflow), 1);

    // Simultaneous write and pop on a full FIFO
    do_reset("rst1");
    tx_hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1);
    check("t4_full", int'(full), 1);
    tx_hold = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_dv && n < 50);
    check("t4_pop_seen", int'(tx_dv), 1);
    rx_dv = 1'b1;
    rx_byte = 8'h30;
    exp_q.push_back(8'h30);
    @(posedge clk);
    #1;
    check("t4_count", int'(count), 16);
    check("t4_full_kept", int'(full), 1);
    check("t4_no_ovf", int'(overflow), 0);
    check("t4_last_byte", int'(last_byte), 8'h30);
    @(negedge clk);
    rx_dv = 1'b0;
    wait_idle("t4_drain_wait", 600);
    check("t4_queue_drained", exp_q.size(), 0);

    // Timeout: transmitter never reports busy
    tx_auto = 1'b0;
    repeat (2) @(negedge clk);
    dv_log.delete();
    send(8'hB1, 1'b1);
    send(8'hB2, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("t5_dv_count", dv_log.size(), 2);
    check("t5_dv_spacing", (dv_log.size() == 2) ? dv_log[1] - dv_log[0] : -1, 6);
    wait_idle("t5_idle_wait", 20);
    check("t5_queue_drained", exp_q.size(), 0);

    // Reset during WAIT_DONE with 3 entries stored
    tx_auto = 1'b1;
    tx_len = 20;
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    n = 0;
    while (n < 40 && !(dut.state == WAIT_DONE && count == 5'd3)) begin
      @(negedge clk);
      n++;
    end
    check("t6_wait_done_3", int'(n < 40), 1);
    do_reset("t6_rst");
    dv_log.delete();
    repeat (40) @(posedge clk);
    #1;
    check("t6_no_dv_after_rst", dv_log.size(), 0);
    check("t6_empty", int'(empty), 1);
    check("t6_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
